// File: rtl/board_state.sv
// Board memory for a 10x10 two-player grid: one registered read port for the
// display path and a move engine that validates and writes moves, with a clear sweep.
module board_state #(
    parameter int N_CELLS      = 100,
    parameter bit CLR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] rd_addr,
    output logic [1:0] rd_data,
    input  logic       mv_valid,
    output logic       mv_ready,
    input  logic [6:0] mv_cell,
    output logic       mv_done,
    output logic       mv_err,
    output logic       turn,
    output logic [6:0] move_count,
    output logic       board_full,
    input  logic       clear_req,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CHECK = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic [6:0] N_CELLS_W = 7'(N_CELLS);
    localparam logic [6:0] LAST_IDX  = 7'(N_CELLS - 1);

    logic [1:0] mem_r [N_CELLS];

    state_t     state_r;
    state_t     state_nx_s;
    logic [6:0] idx_r;
    logic [6:0] cell_r;
    logic       turn_r;
    logic [6:0] count_r;
    logic       mv_done_r;
    logic       mv_err_r;
    logic [1:0] rd_data_r;

    logic       mem_we_s;
    logic [6:0] mem_wa_s;
    logic [1:0] mem_wd_s;
    logic       start_clear_s;
    logic       accept_s;
    logic       reject_s;
    logic       commit_s;
    logic       busy_s;
    logic [1:0] cell_val_s;

    assign busy_s     = (state_r == ST_CLEAR);
    assign busy       = busy_s;
    assign mv_ready   = (state_r == ST_IDLE) && !clear_req;
    assign rd_data    = rd_data_r;
    assign mv_done    = mv_done_r;
    assign mv_err     = mv_err_r;
    assign turn       = turn_r;
    assign move_count = count_r;
    assign board_full = (count_r == N_CELLS_W);

    // Next-state decode plus the single internal write port request.
    always_comb begin
        state_nx_s    = state_r;
        mem_we_s      = 1'b0;
        mem_wa_s      = cell_r;
        mem_wd_s      = 2'b00;
        start_clear_s = 1'b0;
        accept_s      = 1'b0;
        reject_s      = 1'b0;
        commit_s      = 1'b0;
        // Out-of-range targets look occupied so they take the reject path.
        if (cell_r < N_CELLS_W) begin
            cell_val_s = mem_r[cell_r];
        end else begin
            cell_val_s = 2'b11;
        end
        case (state_r)
            ST_CLEAR: begin
                mem_we_s = 1'b1;
                mem_wa_s = idx_r;
                if (idx_r == LAST_IDX) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    start_clear_s = 1'b1;
                    state_nx_s    = ST_CLEAR;
                end else if (mv_valid) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_CHECK;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (cell_val_s != 2'b00) begin
                    reject_s   = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_we_s   = 1'b1;
                mem_wa_s   = cell_r;
                mem_wd_s   = {turn_r, !turn_r};
                commit_s   = 1'b1;
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_CLEAR;
            end
        endcase
    end

    // Control registers: state, sweep index, captured move, turn and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= CLR_ON_RESET ? ST_CLEAR : ST_IDLE;
            idx_r     <= 7'd0;
            cell_r    <= 7'd0;
            turn_r    <= 1'b0;
            count_r   <= 7'd0;
            mv_done_r <= 1'b0;
            mv_err_r  <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            mv_done_r <= commit_s;
            mv_err_r  <= reject_s;
            if (start_clear_s) begin
                idx_r <= 7'd0;
            end else if (state_r == ST_CLEAR) begin
                idx_r <= idx_r + 7'd1;
            end else begin
                idx_r <= idx_r;
            end
            if (accept_s) begin
                cell_r <= mv_cell;
            end else begin
                cell_r <= cell_r;
            end
            if (start_clear_s) begin
                turn_r <= 1'b0;
            end else if (commit_s) begin
                turn_r <= !turn_r;
            end else begin
                turn_r <= turn_r;
            end
            if (start_clear_s) begin
                count_r <= 7'd0;
            end else if (commit_s && (count_r != N_CELLS_W)) begin
                count_r <= count_r + 7'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Cell storage; a reset edge suppresses any in-flight write.
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_r[mem_wa_s] <= mem_wd_s;
        end
    end

    // Registered read port; sees pre-write contents on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= 2'b00;
        end else if (busy_s) begin
            rd_data_r <= 2'b00;
        end else if (rd_addr >= N_CELLS_W) begin
            rd_data_r <= 2'b11;
        end else begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

endmodule

// File: doc/board_state.md
BOARD_STATE -- requirements
Module: board_state

Interface
REQ-001 SHALL have parameter N_CELLS, default 100, number of board cells (10 x 10 grid, index = col + row*10).
REQ-002 SHALL have parameter CLR_ON_RESET, default 1, 1 = run clear sweep after reset, 0 = go straight to IDLE.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rd_addr  input  7  cell index from the pixel/rgb stage.
REQ-006 SHALL have port rd_data  output  2  cell state: 00 empty, 01 triangle, 10 circle, 11 invalid.
REQ-007 SHALL have port mv_valid  input  1  move request valid.
REQ-008 SHALL have port mv_ready  output  1  block can accept a move.
REQ-009 SHALL have port mv_cell  input  7  target cell index of move.
REQ-010 SHALL have port mv_done  output  1  one-cycle pulse, move written.
REQ-011 SHALL have port mv_err  output  1  one-cycle pulse, move rejected.
REQ-012 SHALL have port turn  output  1  side to move: 0 triangle, 1 circle.
REQ-013 SHALL have port move_count  output  7  number of accepted moves since last clear.
REQ-014 SHALL have port board_full  output  1  high when move_count == N_CELLS.
REQ-015 SHALL have port clear_req  input  1  new-game request.
REQ-016 SHALL have port busy  output  1  high while clear sweep runs.

Function
REQ-017 SHALL store N_CELLS x 2-bit entries, with one independent read port and one internal write port.
REQ-018 SHALL register rd_data, so rd_data reflects rd_addr sampled at the previous edge (1-cycle latency).
REQ-019 SHALL return 11 on rd_data for rd_addr >= N_CELLS.
REQ-020 SHALL force rd_data to 00 while busy is high.
REQ-021 SHALL return the old cell value on rd_data when the read and an internal write hit the same address in the same cycle (read-before-write).
REQ-022 SHALL implement FSM states CLEAR, IDLE, CHECK, WRITE.
REQ-023 In CLEAR, SHALL write 00 to one cell per cycle at indices 0..N_CELLS-1, then go to IDLE: exactly N_CELLS cycles, busy high throughout.
REQ-024 SHALL drive mv_ready = (state == IDLE) && !clear_req.
REQ-025 A handshake SHALL occur on a rising edge with mv_valid && mv_ready: capture mv_cell, go to CHECK.
REQ-026 In CHECK, if mv_cell >= N_CELLS or the stored cell != 00, SHALL go to IDLE and pulse mv_err for one cycle after that edge, leaving memory, turn and count unchanged.
REQ-027 In CHECK otherwise, SHALL go to WRITE.
REQ-028 In WRITE, SHALL store {turn, !turn} (01 for triangle, 10 for circle), toggle turn, increment move_count, pulse mv_done for one cycle after that edge, and go to IDLE.
REQ-029 Move latency SHALL be: accept at edge E0, mv_err visible after E1, or write plus mv_done visible after E2; next accept possible at E2 (error) or E3 (success).
REQ-030 clear_req SHALL be sampled only in IDLE and SHALL win over mv_valid in the same cycle; in CHECK/WRITE it SHALL be ignored.
REQ-031 Clear sweep SHALL reset turn to 0 and move_count to 0 at sweep start.
REQ-032 move_count SHALL saturate at N_CELLS.
REQ-033 With board_full high, further moves SHALL still be accepted and then rejected with mv_err.
REQ-034 mv_done and mv_err SHALL never be high in the same cycle.

Reset
REQ-035 rst high SHALL set: state CLEAR (IDLE if CLR_ON_RESET=0), sweep index 0, turn 0, move_count 0, mv_done 0, mv_err 0, rd_data 00, busy 1 (0 if CLR_ON_RESET=0).
REQ-036 rst asserted mid-sweep or mid-move SHALL abort the operation and restart the sweep at index 0; a partial move SHALL never be written.

Verification
REQ-037 Bench SHALL check: release rst -> busy high exactly 100 cycles, mv_ready 0 throughout, then all reads 0..99 return 00, and rd_addr 100/127 return 11.
REQ-038 Bench SHALL check: move to cell 23 -> mv_done 2 edges after accept, rd_data at 23 = 01, turn 1, move_count 1; next move to 24 -> 10, turn 0, count 2.
REQ-039 Bench SHALL check: move to occupied cell 23, and separately to cell 105 -> mv_err pulse 1 edge after accept, board, turn and count unchanged.
REQ-040 Bench SHALL check: 100 legal moves -> board_full 1, move_count 100, cells alternate 01/10; 101st move -> mv_err.
REQ-041 Bench SHALL check: clear_req and mv_valid high together in IDLE -> no handshake, sweep runs, turn 0, count 0; rst pulsed during WRITE -> target cell remains 00 after sweep.
REQ-042 Bench SHALL check: read cell 5 in the same cycle it is written -> rd_data old value 00, then 01 on the following read.
